// File: rtl/predicate_pkg.sv
// Shared sizing constants and the FSM state type for the predicate-file init sequencer.
// No logic lives here; widths derived from these constants are computed where they are used.
package predicate_pkg;

    localparam int NUM_LANES    = 16;
    localparam int NUM_REGS     = 16;
    localparam int NUM_WARPS    = 8;
    localparam int STARVE_LIMIT = 4;
    localparam int STARVE_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } init_state_e;

endpackage

// File: rtl/predicate_init_sequencer.sv
// Clears one warp's predicate file (reg 0 <= mask, others <= 0), sharing the write port with the pipeline.
// pr_* outputs are registered (1-cycle latency); the pipeline wins arbitration except for same-warp writes and starvation relief.
module predicate_init_sequencer
    import predicate_pkg::*;
#(
    parameter int NUM_LANES = predicate_pkg::NUM_LANES,
    parameter int NUM_REGS  = predicate_pkg::NUM_REGS,
    parameter int NUM_WARPS = predicate_pkg::NUM_WARPS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_req,
    input  logic [$clog2(NUM_WARPS)-1:0]  init_warp,
    input  logic [NUM_LANES-1:0]          init_mask,
    output logic                          init_ack,
    output logic                          init_done,
    output logic                          busy,
    input  logic                          pipe_wr_valid,
    input  logic [$clog2(NUM_WARPS)-1:0]  pipe_wr_warp,
    input  logic [$clog2(NUM_REGS)-1:0]   pipe_wr_addr,
    input  logic [NUM_LANES-1:0]          pipe_wr_en,
    input  logic [NUM_LANES-1:0]          pipe_wr_data,
    output logic                          pipe_wr_ready,
    output logic [NUM_LANES-1:0]          pr_write_en,
    output logic [$clog2(NUM_REGS)-1:0]   pr_waddr,
    output logic [NUM_LANES-1:0]          pr_wdata,
    output logic [$clog2(NUM_WARPS)-1:0]  pr_warp_sel
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int WW = $clog2(NUM_WARPS);

    init_state_e           state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [WW-1:0]         warp_q, warp_d;
    logic [NUM_LANES-1:0]  mask_q, mask_d;
    logic [NUM_LANES-1:0]  pr_write_en_q, pr_write_en_d;
    logic [AW-1:0]         pr_waddr_q, pr_waddr_d;
    logic [NUM_LANES-1:0]  pr_wdata_q, pr_wdata_d;
    logic [WW-1:0]         pr_warp_sel_q, pr_warp_sel_d;

    logic conflict;
    logic starve_force;
    logic pipe_grant;
    logic seq_grant;
    logic last_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q        <= '0;
            starve_q      <= '0;
            warp_q        <= '0;
            mask_q        <= '0;
            pr_write_en_q <= '0;
            pr_waddr_q    <= '0;
            pr_wdata_q    <= '0;
            pr_warp_sel_q <= '0;
        end else begin
            addr_q        <= addr_d;
            starve_q      <= starve_d;
            warp_q        <= warp_d;
            mask_q        <= mask_d;
            pr_write_en_q <= pr_write_en_d;
            pr_waddr_q    <= pr_waddr_d;
            pr_wdata_q    <= pr_wdata_d;
            pr_warp_sel_q <= pr_warp_sel_d;
        end
    end

    // Arbitration: a same-warp pipeline write must wait until the whole file is rebuilt.
    always_comb begin
        busy          = (state_q != ST_IDLE);
        init_done     = (state_q == ST_DONE);
        init_ack      = init_req && (state_q == ST_IDLE);
        conflict      = busy && (pipe_wr_warp == warp_q);
        starve_force  = (state_q == ST_CLEAR) && (starve_q == STARVE_W'(STARVE_LIMIT));
        pipe_wr_ready = !conflict && !starve_force;
        pipe_grant    = pipe_wr_valid && pipe_wr_ready;
        seq_grant     = (state_q == ST_CLEAR) && !pipe_grant;
        last_addr     = (addr_q == AW'(NUM_REGS - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (init_req) state_d = ST_CLEAR;
            ST_CLEAR: if (seq_grant && last_addr) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        starve_d = starve_q;
        warp_d   = warp_q;
        mask_d   = mask_q;
        if (init_ack) begin
            addr_d   = '0;
            starve_d = '0;
            warp_d   = init_warp;
            mask_d   = init_mask;
        end else if (seq_grant) begin
            addr_d   = addr_q + AW'(1);
            starve_d = '0;
        end else if ((state_q == ST_CLEAR) && pipe_grant) begin
            starve_d = starve_q + STARVE_W'(1);
        end else if (state_q != ST_CLEAR) begin
            starve_d = '0;
        end
    end

    always_comb begin
        pr_write_en_d = '0;
        pr_waddr_d    = '0;
        pr_wdata_d    = '0;
        pr_warp_sel_d = '0;
        if (pipe_grant) begin
            pr_write_en_d = pipe_wr_en;
            pr_waddr_d    = pipe_wr_addr;
            pr_wdata_d    = pipe_wr_data;
            pr_warp_sel_d = pipe_wr_warp;
        end else if (seq_grant) begin
            pr_write_en_d = '1;
            pr_waddr_d    = addr_q;
            pr_wdata_d    = (addr_q == '0) ? mask_q : '0;
            pr_warp_sel_d = warp_q;
        end
    end

    assign pr_write_en = pr_write_en_q;
    assign pr_waddr    = pr_waddr_q;
    assign pr_wdata    = pr_wdata_q;
    assign pr_warp_sel = pr_warp_sel_q;

endmodule

// File: tb/tb_predicate_init_sequencer.sv
// Directed bench: idle pass-through table, then init / conflict / starvation / back-to-back / reset-abort sequences.
module tb_predicate_init_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_req;
    logic [2:0]  init_warp;
    logic [15:0] init_mask;
    logic        init_ack;
    logic        init_done;
    logic        busy;
    logic        pipe_wr_valid;
    logic [2:0]  pipe_wr_warp;
    logic [3:0]  pipe_wr_addr;
    logic [15:0] pipe_wr_en;
    logic [15:0] pipe_wr_data;
    logic        pipe_wr_ready;
    logic [15:0] pr_write_en;
    logic [3:0]  pr_waddr;
    logic [15:0] pr_wdata;
    logic [2:0]  pr_warp_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    predicate_init_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .init_req      (init_req),
        .init_warp     (init_warp),
        .init_mask     (init_mask),
        .init_ack      (init_ack),
        .init_done     (init_done),
        .busy          (busy),
        .pipe_wr_valid (pipe_wr_valid),
        .pipe_wr_warp  (pipe_wr_warp),
        .pipe_wr_addr  (pipe_wr_addr),
        .pipe_wr_en    (pipe_wr_en),
        .pipe_wr_data  (pipe_wr_data),
        .pipe_wr_ready (pipe_wr_ready),
        .pr_write_en   (pr_write_en),
        .pr_waddr      (pr_waddr),
        .pr_wdata      (pr_wdata),
        .pr_warp_sel   (pr_warp_sel)
    );

    typedef struct {
        logic        vld;
        logic [2:0]  warp;
        logic [3:0]  addr;
        logic [15:0] en;
        logic [15:0] data;
        logic        exp_rdy;
        logic [15:0] exp_en;
        logic        exp_fields;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic seq_write_chk(input int k, input logic [2:0] w, input logic [15:0] m);
        chk($sformatf("seq_en[%0d]", k), pr_write_en, 16'hFFFF);
        chk($sformatf("seq_addr[%0d]", k), pr_waddr, k);
        chk($sformatf("seq_data[%0d]", k), pr_wdata, (k == 0) ? m : 16'h0000);
        chk($sformatf("seq_warp[%0d]", k), pr_warp_sel, w);
    endtask

    // Called at the negedge right after the acking edge: 16 writes, then one-cycle done.
    task automatic clear_tail_chk(input logic [2:0] w, input logic [15:0] m);
        chk("busy_clear", busy, 1);
        for (int k = 0; k < 16; k++) begin
            tick();
            seq_write_chk(k, w, m);
            chk($sformatf("done_at[%0d]", k), init_done, (k == 15) ? 1 : 0);
        end
        tick();
        chk("done_pulse_end", init_done, 0);
        chk("busy_idle", busy, 0);
        chk("idle_no_write", pr_write_en, 0);
    endtask

    task automatic run_init(input logic [2:0] w, input logic [15:0] m);
        init_req  = 1'b1;
        init_warp = w;
        init_mask = m;
        #1 chk("ack_idle", init_ack, 1);
        tick();
        chk("ack_low_clear", init_ack, 0);
        init_req = 1'b0;
        clear_tail_chk(w, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 3'd1, 4'd2,  16'h00FF, 16'h0F0F, 1'b1, 16'h00FF, 1'b1};
        vecs[1] = '{1'b0, 3'd6, 4'd3,  16'hFFFF, 16'hAAAA, 1'b1, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 3'd7, 4'd15, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 3'd0, 4'd0,  16'h0000, 16'h1234, 1'b1, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 3'd5, 4'd9,  16'h8001, 16'hC3C3, 1'b1, 16'h8001, 1'b1};

        rst = 1'b1;
        init_req = 1'b0; init_warp = '0; init_mask = '0;
        pipe_wr_valid = 1'b0; pipe_wr_warp = '0; pipe_wr_addr = '0;
        pipe_wr_en = '0; pipe_wr_data = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", init_done, 0);
        chk("rst_en", pr_write_en, 0);
        chk("rst_addr", pr_waddr, 0);
        chk("rst_data", pr_wdata, 0);
        chk("rst_warp", pr_warp_sel, 0);
        chk("rst_ready_idle", pipe_wr_ready, 1);
        rst = 1'b0;
        tick();

        // Idle pass-through table
        for (int i = 0; i < 5; i++) begin
            pipe_wr_valid = vecs[i].vld;
            pipe_wr_warp  = vecs[i].warp;
            pipe_wr_addr  = vecs[i].addr;
            pipe_wr_en    = vecs[i].en;
            pipe_wr_data  = vecs[i].data;
            #1 chk($sformatf("vec%0d_ready", i), pipe_wr_ready, vecs[i].exp_rdy);
            tick();
            chk($sformatf("vec%0d_en", i), pr_write_en, vecs[i].exp_en);
            if (vecs[i].exp_fields) begin
                chk($sformatf("vec%0d_addr", i), pr_waddr, vecs[i].addr);
                chk($sformatf("vec%0d_data", i), pr_wdata, vecs[i].data);
                chk($sformatf("vec%0d_warp", i), pr_warp_sel, vecs[i].warp);
            end
        end
        pipe_wr_valid = 1'b0;
        tick();

        // Plain init of warp 3
        run_init(3'd3, 16'hA5A5);

        // Same-warp conflict: pipe write to warp 2 stalls until the first idle cycle
        init_req = 1'b1; init_warp = 3'd2; init_mask = 16'h0C0C;
        #1 chk("cf_ack", init_ack, 1);
        tick();
        init_req = 1'b0;
        pipe_wr_valid = 1'b1; pipe_wr_warp = 3'd2; pipe_wr_addr = 4'd5;
        pipe_wr_en = 16'h00F0; pipe_wr_data = 16'h0030;
        #1 chk("cf_ready_c1", pipe_wr_ready, 0);
        for (int c = 2; c <= 17; c++) begin
            tick();
            chk($sformatf("cf_ready_c%0d", c), pipe_wr_ready, 0);
            seq_write_chk(c - 2, 3'd2, 16'h0C0C);
            chk($sformatf("cf_done_c%0d", c), init_done, (c == 17) ? 1 : 0);
        end
        tick();
        chk("cf_ready_idle", pipe_wr_ready, 1);
        chk("cf_busy_idle", busy, 0);
        chk("cf_no_write_done", pr_write_en, 0);
        tick();
        pipe_wr_valid = 1'b0;
        chk("cf_pipe_en", pr_write_en, 16'h00F0);
        chk("cf_pipe_addr", pr_waddr, 5);
        chk("cf_pipe_data", pr_wdata, 16'h0030);
        chk("cf_pipe_warp", pr_warp_sel, 2);
        tick();

        // Starvation: warp 4 streams every cycle; sequencer gets every 5th slot
        init_req = 1'b1; init_warp = 3'd1; init_mask = 16'h0F0F;
        #1 chk("sv_ack", init_ack, 1);
        tick();
        init_req = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            logic [7:0]  cb;
            logic [15:0] exp_en, exp_data;
            cb = 8'(c);
            exp_en   = {8'hC0, cb} | 16'h0001;
            exp_data = 16'hB000 ^ {8'h00, cb};
            pipe_wr_valid = 1'b1;
            pipe_wr_warp  = 3'd4;
            pipe_wr_addr  = cb[3:0];
            pipe_wr_en    = exp_en;
            pipe_wr_data  = exp_data;
            #1 chk($sformatf("sv_ready_c%0d", c), pipe_wr_ready, (c % 5 != 0) ? 1 : 0);
            chk($sformatf("sv_busy_c%0d", c), busy, 1);
            tick();
            if (c % 5 == 0) begin
                seq_write_chk(c / 5 - 1, 3'd1, 16'h0F0F);
            end else begin
                chk($sformatf("sv_pen_c%0d", c), pr_write_en, exp_en);
                chk($sformatf("sv_paddr_c%0d", c), pr_waddr, cb[3:0]);
                chk($sformatf("sv_pdata_c%0d", c), pr_wdata, exp_data);
                chk($sformatf("sv_pwarp_c%0d", c), pr_warp_sel, 4);
            end
        end
        pipe_wr_valid = 1'b0;
        chk("sv_done", init_done, 1);
        tick();
        chk("sv_done_end", init_done, 0);
        chk("sv_idle_no_write", pr_write_en, 0);

        // Back-to-back: request held across the first sequence
        init_req = 1'b1; init_warp = 3'd0; init_mask = 16'h8001;
        #1 chk("bb_ack0", init_ack, 1);
        tick();
        init_warp = 3'd7; init_mask = 16'h1234;
        #1 chk("bb_ack_c1", init_ack, 0);
        for (int c = 2; c <= 17; c++) begin
            tick();
            seq_write_chk(c - 2, 3'd0, 16'h8001);
            chk($sformatf("bb_ack_c%0d", c), init_ack, 0);
            chk($sformatf("bb_done_c%0d", c), init_done, (c == 17) ? 1 : 0);
        end
        tick();
        chk("bb_ack1", init_ack, 1);
        chk("bb_busy_gap", busy, 0);
        tick();
        init_req = 1'b0;
        clear_tail_chk(3'd7, 16'h1234);

        // Reset during CLEAR after address 6 is written
        init_req = 1'b1; init_warp = 3'd5; init_mask = 16'h5A5A;
        #1 chk("rs_ack", init_ack, 1);
        tick();
        init_req = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            tick();
            seq_write_chk(k, 3'd5, 16'h5A5A);
        end
        #1 rst = 1'b1;
        #1;
        chk("rs_en", pr_write_en, 0);
        chk("rs_addr", pr_waddr, 0);
        chk("rs_data", pr_wdata, 0);
        chk("rs_warp", pr_warp_sel, 0);
        chk("rs_busy", busy, 0);
        chk("rs_done", init_done, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rs_hold_done%0d", c), init_done, 0);
            chk($sformatf("rs_hold_en%0d", c), pr_write_en, 0);
        end
        rst = 1'b0;
        run_init(3'd6, 16'h00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
